line_mem_responder: RTL and testbench

- Line-granular main-memory responder that serves the memory side of the cache↔memory handshake (`gnt`/`rd_req`/`wr_req`/line data).
- Sits below any cache controller in the lab design.
- Holds 2^ADDR_LEN lines of LINE_SIZE 32-bit words.
- Each request takes LATENCY cycles of programmable delay and completes with a one-cycle `gnt` pulse.
- Keeps read/write transaction counters for hit/miss-rate experiments.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/line_mem_responder_if.sv | 38 +++
 rtl/line_mem_array.sv | 55 +++++
 rtl/line_mem_responder.sv | 118 +++++++++++
 tb/tb_line_mem_responder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the line-granular memory responder:
//   - state_e : responder FSM states (IDLE, BUSY, DONE)
//   - op_e    : operation latched at accept (READ / WRITE)
//   - word_t  : one 32-bit storage word
//   - line_t  : one line at the default geometry (8 words)
//   - line_size() : words per line from log2(words per line)
// -----------------------------------------------------------------------------
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

   typedef logic [31:0] word_t;

   localparam int DEF_LINE_ADDR_LEN = 3;

   function automatic int line_size(input int line_addr_len);
      return 1 << line_addr_len;
   endfunction

   // Word i of a line is element [i]; modules with non-default geometry
   // build the same shape from word_t and their own LINE_SIZE.
   typedef word_t [line_size(DEF_LINE_ADDR_LEN)-1:0] line_t;

endpackage

// File: rtl/line_mem_responder_if.sv
// -----------------------------------------------------------------------------
// line_mem_responder_if
// Cache <-> memory line handshake.
//   gnt     : one-cycle completion pulse (memory -> cache)
//   addr    : line address, sampled at accept (cache -> memory)
//   rd_req  : read request level, held until gnt (cache -> memory)
//   wr_req  : write request level, held until gnt (cache -> memory)
//   rd_line : read line data, valid from the gnt cycle (memory -> cache)
//   wr_line : write line data, sampled at accept (cache -> memory)
// Modports: master = cache side, slave = memory side.
// -----------------------------------------------------------------------------
interface line_mem_responder_if
   import mem_pkg::*;
#(
   parameter int ADDR_LEN      = 9,
   parameter int LINE_ADDR_LEN = 3
) ();

   localparam int LINE_SIZE = line_size(LINE_ADDR_LEN);

   logic                        gnt;
   logic [ADDR_LEN-1:0]         addr;
   logic                        rd_req;
   logic                        wr_req;
   logic [LINE_SIZE-1:0][31:0]  rd_line;
   logic [LINE_SIZE-1:0][31:0]  wr_line;

   modport master (
      input  gnt, rd_line,
      output addr, rd_req, wr_req, wr_line
   );

   modport slave (
      output gnt, rd_line,
      input  addr, rd_req, wr_req, wr_line
   );

endinterface

// File: rtl/line_mem_array.sv
// -----------------------------------------------------------------------------
// line_mem_array
// Synchronous line storage, 2^ADDR_LEN lines of 2^LINE_ADDR_LEN words.
// On rst every word w of line L is loaded with L*LINE_SIZE + w.
//   clk, rst   : clock, synchronous active-high reset
//   i_wr_en    : commit i_wr_line to line i_wr_addr
//   i_rd_en    : load o_rd_line from line i_rd_addr (registered)
//   o_rd_line  : last line read; holds between reads, 0 after reset
// -----------------------------------------------------------------------------
module line_mem_array
   import mem_pkg::*;
#(
   parameter int ADDR_LEN      = 9,
   parameter int LINE_ADDR_LEN = 3
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        i_wr_en,
   input  logic [ADDR_LEN-1:0]                         i_wr_addr,
   input  logic [line_size(LINE_ADDR_LEN)-1:0][31:0]   i_wr_line,
   input  logic                                        i_rd_en,
   input  logic [ADDR_LEN-1:0]                         i_rd_addr,
   output logic [line_size(LINE_ADDR_LEN)-1:0][31:0]   o_rd_line
);

   localparam int LINE_SIZE = line_size(LINE_ADDR_LEN);
   localparam int NUM_LINES = 1 << ADDR_LEN;

   logic [LINE_SIZE-1:0][31:0] r_mem [NUM_LINES];
   logic [LINE_SIZE-1:0][31:0] r_rd_line;

   // NOTE: storage is deliberately reset: the initiator relies on the
   // address-pattern contents after every reset, so this array maps to
   // flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int l = 0; l < NUM_LINES; l++) begin
            for (int w = 0; w < LINE_SIZE; w++) begin
               r_mem[l[ADDR_LEN-1:0]][w[LINE_ADDR_LEN-1:0]] <= 32'(l * LINE_SIZE + w);
            end
         end
         r_rd_line <= '0;
      end else begin
         if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_line;
         end
         if (i_rd_en) begin
            r_rd_line <= r_mem[i_rd_addr];
         end
      end
   end

   assign o_rd_line = r_rd_line;

endmodule

// File: rtl/line_mem_responder.sv
// -----------------------------------------------------------------------------
// line_mem_responder
// Memory side of the cache line handshake. Accepts one request in IDLE
// (write wins over read), waits LATENCY cycles in BUSY, commits/reads the
// line on the last BUSY edge, then pulses gnt for one cycle in DONE.
//   clk, rst : clock, synchronous active-high reset
//   bus      : line handshake, slave side
//   rd_cnt   : completed reads since reset (wraps at 2^32)
//   wr_cnt   : completed writes since reset (wraps at 2^32)
// -----------------------------------------------------------------------------
module line_mem_responder
   import mem_pkg::*;
#(
   parameter int LINE_ADDR_LEN = 3,
   parameter int ADDR_LEN      = 9,
   parameter int LATENCY       = 4
) (
   input  logic                clk,
   input  logic                rst,
   line_mem_responder_if.slave bus,
   output logic [31:0]         rd_cnt,
   output logic [31:0]         wr_cnt
);

   localparam int LINE_SIZE = line_size(LINE_ADDR_LEN);

   state_e                     r_state;
   op_e                        r_op;
   logic [7:0]                 r_cnt;
   logic [ADDR_LEN-1:0]        r_addr;
   logic [LINE_SIZE-1:0][31:0] r_wr_line;
   logic                       r_gnt;
   logic [31:0]                r_rd_cnt;
   logic [31:0]                r_wr_cnt;

   logic                       w_last;
   logic                       w_wr_en;
   logic                       w_rd_en;
   logic [LINE_SIZE-1:0][31:0] w_rd_line;

   // Storage access happens on the same edge that leaves BUSY, so the
   // data is in place exactly when gnt rises.
   assign w_last  = (r_state == BUSY) && (r_cnt == 8'd0);
   assign w_wr_en = w_last && (r_op == OP_WRITE);
   assign w_rd_en = w_last && (r_op == OP_READ);

   line_mem_array #(
      .ADDR_LEN      (ADDR_LEN),
      .LINE_ADDR_LEN (LINE_ADDR_LEN)
   ) u_array (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_addr),
      .i_wr_line (r_wr_line),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (r_addr),
      .o_rd_line (w_rd_line)
   );

   // NOTE: all state here is updated with non-blocking assignments so every
   // branch sees the pre-edge values of r_state, r_cnt and r_op.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_op      <= OP_READ;
         r_cnt     <= 8'd0;
         r_addr    <= '0;
         r_wr_line <= '0;
         r_gnt     <= 1'b0;
         r_rd_cnt  <= 32'd0;
         r_wr_cnt  <= 32'd0;
      end else begin
         r_gnt <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.wr_req) begin
                  r_addr    <= bus.addr;
                  r_wr_line <= bus.wr_line;
                  r_op      <= OP_WRITE;
                  r_cnt     <= 8'(LATENCY - 1);
                  r_state   <= BUSY;
               end else if (bus.rd_req) begin
                  r_addr  <= bus.addr;
                  r_op    <= OP_READ;
                  r_cnt   <= 8'(LATENCY - 1);
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (r_cnt == 8'd0) begin
                  r_state <= DONE;
                  r_gnt   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            DONE: begin
               // Requests are still held by the initiator here; they are
               // ignored until the FSM is back in IDLE.
               r_state <= IDLE;
               if (r_op == OP_WRITE) begin
                  r_wr_cnt <= r_wr_cnt + 32'd1;
               end else begin
                  r_rd_cnt <= r_rd_cnt + 32'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.rd_line = w_rd_line;
   assign rd_cnt      = r_rd_cnt;
   assign wr_cnt      = r_wr_cnt;

endmodule

// File: tb/tb_line_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_line_mem_responder
// Directed bench for line_mem_responder at default parameters
// (8-word lines, 512 lines, LATENCY=4). Inputs change on the falling edge,
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_line_mem_responder;
   import mem_pkg::*;

   localparam int LINE_ADDR_LEN = 3;
   localparam int ADDR_LEN      = 9;
   localparam int LATENCY       = 4;
   localparam int LINE_SIZE     = 8;
   localparam int MAX_WAIT      = 20;

   logic        clk;
   logic        rst;
   logic [31:0] rd_cnt;
   logic [31:0] wr_cnt;

   int n_total;
   int n_bad;
   int n_gnt;
   int exp_gnt;
   int cyc;
   int cyc2;

   line_mem_responder_if #(.ADDR_LEN(ADDR_LEN), .LINE_ADDR_LEN(LINE_ADDR_LEN)) bus ();

   line_mem_responder #(
      .LINE_ADDR_LEN (LINE_ADDR_LEN),
      .ADDR_LEN      (ADDR_LEN),
      .LATENCY       (LATENCY)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .rd_cnt (rd_cnt),
      .wr_cnt (wr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts gnt pulses: gnt is sampled just before each rising edge updates it.
   always @(posedge clk) begin
      if (bus.gnt === 1'b1) n_gnt++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Compares all words of rd_line against base+i (or fill when base_mode=0).
   task automatic check_line(input string tag, input logic [31:0] base, input bit incr);
      for (int i = 0; i < LINE_SIZE; i++) begin
         check($sformatf("%s[%0d]", tag, i), bus.rd_line[i[2:0]],
               incr ? base + 32'(i) : base);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Issues a request at a falling edge (that cycle is cycle 0) and returns
   // the cycle in which gnt is seen, or 0 if it never arrives. With drop set,
   // addr is changed to drop_addr and the request dropped right after accept.
   task automatic txn(input bit rd, input bit wr, input logic [ADDR_LEN-1:0] a,
                      input logic [31:0] base, input bit incr,
                      input bit drop, input logic [ADDR_LEN-1:0] drop_addr,
                      output int gcyc);
      bus.rd_req = rd;
      bus.wr_req = wr;
      bus.addr   = a;
      for (int i = 0; i < LINE_SIZE; i++) begin
         bus.wr_line[i[2:0]] = incr ? base + 32'(i) : base;
      end
      gcyc = 0;
      for (int k = 1; k <= MAX_WAIT; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (drop && k == 1) begin
            bus.rd_req  = 1'b0;
            bus.wr_req  = 1'b0;
            bus.addr    = drop_addr;
            bus.wr_line = '1;
         end
         if (bus.gnt === 1'b1) begin
            gcyc = k;
            break;
         end
      end
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b0;
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      n_gnt   = 0;
      exp_gnt = 0;
      rst         = 1'b1;
      bus.rd_req  = 1'b0;
      bus.wr_req  = 1'b0;
      bus.addr    = '0;
      bus.wr_line = '0;
      idle(2);
      rst = 1'b0;
      idle(1);

      // Reset state
      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check("rst_rd_cnt", rd_cnt, 32'd0);
      check("rst_wr_cnt", wr_cnt, 32'd0);
      check_line("rst_rd_line", 32'd0, 1'b0);

      // Read line 5: gnt in cycle LATENCY+1, words 40+i
      txn(1'b1, 1'b0, 9'd5, 32'd0, 1'b0, 1'b0, 9'd0, cyc);
      exp_gnt++;
      check("rd5_gnt_cycle", 32'(cyc), 32'd5);
      check_line("rd5_line", 32'd40, 1'b1);
      idle(1);
      check("rd5_rd_cnt", rd_cnt, 32'd1);
      check("rd5_gnt_pulses", 32'(n_gnt), 32'(exp_gnt));

      // Write line 5 with DEADBEEF; rd_line must keep 40+i
      txn(1'b0, 1'b1, 9'd5, 32'hDEADBEEF, 1'b0, 1'b0, 9'd0, cyc);
      exp_gnt++;
      check("wr5_gnt_cycle", 32'(cyc), 32'd5);
      check_line("wr5_rd_line_kept", 32'd40, 1'b1);
      idle(1);
      check("wr5_wr_cnt", wr_cnt, 32'd1);
      check("wr5_rd_cnt", rd_cnt, 32'd1);
      txn(1'b1, 1'b0, 9'd5, 32'd0, 1'b0, 1'b0, 9'd0, cyc);
      exp_gnt++;
      check("raw5_gnt_cycle", 32'(cyc), 32'd5);
      check_line("raw5_line", 32'hDEADBEEF, 1'b0);
      idle(1);

      // Write-back: write line 3, then read line 9 issued during DONE
      txn(1'b0, 1'b1, 9'd3, 32'h3000_0000, 1'b1, 1'b0, 9'd0, cyc);
      exp_gnt++;
      txn(1'b1, 1'b0, 9'd9, 32'd0, 1'b0, 1'b0, 9'd0, cyc2);
      exp_gnt++;
      check("wb_wr_gnt_cycle", 32'(cyc), 32'd5);
      check("wb_total_cycles", 32'(cyc + cyc2), 32'd11);
      check_line("wb_rd9_line", 32'd72, 1'b1);
      idle(1);
      check("wb_gnt_pulses", 32'(n_gnt), 32'(exp_gnt));
      check("wb_wr_cnt", wr_cnt, 32'd2);
      check("wb_rd_cnt", rd_cnt, 32'd3);

      // Both requests high on line 7: write wins, read not counted
      txn(1'b1, 1'b1, 9'd7, 32'hA5A5_0000, 1'b1, 1'b0, 9'd0, cyc);
      exp_gnt++;
      check("both_gnt_cycle", 32'(cyc), 32'd5);
      check_line("both_rd_line_kept", 32'd72, 1'b1);
      idle(1);
      check("both_wr_cnt", wr_cnt, 32'd3);
      check("both_rd_cnt", rd_cnt, 32'd3);
      txn(1'b1, 1'b0, 9'd7, 32'd0, 1'b0, 1'b0, 9'd0, cyc);
      exp_gnt++;
      check_line("both_rd7_line", 32'hA5A5_0000, 1'b1);
      idle(1);
      check("both_rd7_rd_cnt", rd_cnt, 32'd4);

      // Reset during BUSY cycle 2 of a write to line 5
      bus.wr_req  = 1'b1;
      bus.addr    = 9'd5;
      bus.wr_line = {LINE_SIZE{32'h1234_5678}};
      idle(2);
      rst        = 1'b1;
      bus.wr_req = 1'b0;
      idle(1);
      rst = 1'b0;
      idle(8);
      check("mrst_gnt_pulses", 32'(n_gnt), 32'(exp_gnt));
      check("mrst_rd_cnt", rd_cnt, 32'd0);
      check("mrst_wr_cnt", wr_cnt, 32'd0);
      txn(1'b1, 1'b0, 9'd5, 32'd0, 1'b0, 1'b0, 9'd0, cyc);
      exp_gnt++;
      check("mrst_rd5_gnt_cycle", 32'(cyc), 32'd5);
      check_line("mrst_rd5_line", 32'd40, 1'b1);
      idle(1);
      check("mrst_rd5_rd_cnt", rd_cnt, 32'd1);

      // Read line 2, then change addr to 6 and drop rd_req after accept
      txn(1'b1, 1'b0, 9'd2, 32'd0, 1'b0, 1'b1, 9'd6, cyc);
      exp_gnt++;
      check("drop_gnt_cycle", 32'(cyc), 32'd5);
      check_line("drop_rd2_line", 32'd16, 1'b1);
      idle(3);
      check("drop_rd_cnt", rd_cnt, 32'd2);
      check("drop_gnt_pulses", 32'(n_gnt), 32'(exp_gnt));
      check("final_gnt_low", 32'(bus.gnt), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
